// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: sequences LEN operand pairs through an external MAC PE and returns the dot product
module mac_seq_ctrl #(
  parameter int REG_WIDTH = 16,
  parameter int LEN_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] len,
  output logic                 busy,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [REG_WIDTH-1:0] in_a,
  input  logic [REG_WIDTH-1:0] in_b,
  output logic [REG_WIDTH-1:0] pe_a,
  output logic [REG_WIDTH-1:0] pe_b,
  output logic [REG_WIDTH-1:0] pe_c,
  input  logic [REG_WIDTH-1:0] pe_sum,
  output logic [LEN_WIDTH-1:0] beat_cnt,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [REG_WIDTH-1:0] out_data
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0]           state;
  logic [REG_WIDTH-1:0] acc;
  logic [LEN_WIDTH-1:0] len_q;
  logic                 beat;
  logic                 last;
  // Status, handshake and PE wiring derived from the current state
  always_comb begin
    busy      = state != IDLE;
    in_ready  = state == RUN;
    out_valid = state == DONE;
    out_data  = acc;
    pe_a      = in_a;
    pe_b      = in_b;
    pe_c      = acc;
    beat      = in_valid && in_ready;
    last      = beat_cnt == len_q - LEN_WIDTH'(1);
  end
  // Command FSM, accumulator and beat counter; clear outranks everything but reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      acc      <= '0;
      beat_cnt <= '0;
      len_q    <= '0;
    end else if (clear) begin
      state    <= IDLE;
      acc      <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          acc <= '0;
          if (len != '0) begin
            len_q    <= len;
            beat_cnt <= '0;
            state    <= RUN;
          end else begin
            state <= DONE;
          end
        end
        RUN: if (beat) begin
          acc      <= pe_sum;
          beat_cnt <= beat_cnt + LEN_WIDTH'(1);
          if (last) state <= DONE;
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
